// File: rtl/sdram_pkg.sv
// Shared SDRAM read-sequencer constants: command encodings {CS_N,RAS_N,CAS_N,WE_N},
// DQM levels, FSM state encodings and a small constant helper.
package sdram_pkg;

  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_ACT  = 4'b0011;
  localparam logic [3:0] CMD_READ = 4'b0101;
  localparam logic [3:0] CMD_PRE  = 4'b0010;

  localparam logic [1:0] DQM_ON  = 2'b11;
  localparam logic [1:0] DQM_OFF = 2'b00;

  typedef logic [3:0] sdram_rd_state_t;

  localparam sdram_rd_state_t ST_IDLE = 4'd0;
  localparam sdram_rd_state_t ST_ACT  = 4'd1;
  localparam sdram_rd_state_t ST_TRCD = 4'd2;
  localparam sdram_rd_state_t ST_RD   = 4'd3;
  localparam sdram_rd_state_t ST_CASW = 4'd4;
  localparam sdram_rd_state_t ST_CAP  = 4'd5;
  localparam sdram_rd_state_t ST_PRE  = 4'd6;
  localparam sdram_rd_state_t ST_TRP  = 4'd7;
  localparam sdram_rd_state_t ST_FIN  = 4'd8;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/sdram_wait_ctr.sv
// Loadable down-counter shared by every timed state of the read sequencer;
// zero_o marks the last cycle of the current wait.
module sdram_wait_ctr #(
  parameter int W = 4
) (
  input  logic         iclk,
  input  logic         ctr_reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge iclk or posedge ctr_reset) begin
    if (ctr_reset) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/sdram_burst_reader.sv
// SDRAM burst read sequencer: ACT -> tRCD -> READ -> CAS wait -> capture -> precharge -> FIN.
// Define SDRAM_RD_AUTO_PRECHARGE_EN to issue READ with auto-precharge and skip the PRE command.
module sdram_burst_reader
  import sdram_pkg::*;
#(
  parameter int DB_WIDTH  = 16,
  parameter int BURST_LEN = 8,
  parameter int ROW_W     = 13,
  parameter int COL_W     = 10,
  parameter int BA_W      = 2,
  parameter int CAS_LAT   = 2,
  parameter int T_RCD     = 2,
  parameter int T_RP      = 2
) (
  input  logic                          iclk,
  input  logic                          ctr_reset,
  input  logic                          ireq,
  input  logic                          ienb,
  input  logic [ROW_W-1:0]              irow,
  input  logic [COL_W-1:0]              icolumn,
  input  logic [BA_W-1:0]               ibank,
  output logic                          obusy,
  output logic                          obeat_vld,
  output logic [DB_WIDTH-1:0]           obeat,
  output logic                          ofin,
  output logic [DB_WIDTH*BURST_LEN-1:0] odata,
  output logic                          DRAM_CLK,
  output logic                          DRAM_CKE,
  output logic                          DRAM_CS_N,
  output logic                          DRAM_RAS_N,
  output logic                          DRAM_CAS_N,
  output logic                          DRAM_WE_N,
  output logic                          DRAM_LDQM,
  output logic                          DRAM_UDQM,
  output logic [ROW_W-1:0]              DRAM_ADDR,
  output logic [BA_W-1:0]               DRAM_BA,
  input  logic [DB_WIDTH-1:0]           DRAM_DQ
);

  localparam int CNT_W = $clog2(max4(T_RCD, CAS_LAT, T_RP, BURST_LEN)) + 1;
  localparam int ACC_W = DB_WIDTH * BURST_LEN;

`ifdef SDRAM_RD_AUTO_PRECHARGE_EN
  localparam logic AUTO_PRE = 1'b1;
`else
  localparam logic AUTO_PRE = 1'b0;
`endif

  sdram_rd_state_t   state_q, state_d;
  logic [COL_W-1:0]  col_q;
  logic [BA_W-1:0]   bank_q;
  logic [3:0]        cmd_q, cmd_d;
  logic [ROW_W-1:0]  addr_q, addr_d;
  logic [BA_W-1:0]   ba_q, ba_d;
  logic [1:0]        dqm_q, dqm_d;
  logic              obeat_vld_q;
  logic [DB_WIDTH-1:0] obeat_q;
  logic              ofin_q;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [ACC_W-1:0]  odata_q;
  logic              cnt_load;
  logic [CNT_W-1:0]  cnt_load_val;
  logic              cnt_zero;
  logic              cap_d;

  sdram_wait_ctr #(.W(CNT_W)) u_wait_ctr (
    .iclk       (iclk),
    .ctr_reset  (ctr_reset),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .zero_o     (cnt_zero)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (ireq) state_d = ST_ACT;
      ST_ACT:  state_d = (T_RCD > 1) ? ST_TRCD : ST_RD;
      ST_TRCD: if (cnt_zero) state_d = ST_RD;
      ST_RD:   state_d = ST_CASW;
      ST_CASW: if (cnt_zero) state_d = ST_CAP;
`ifdef SDRAM_RD_AUTO_PRECHARGE_EN
      ST_CAP:  if (cnt_zero) state_d = ST_TRP;
`else
      ST_CAP:  if (cnt_zero) state_d = ST_PRE;
`endif
      ST_PRE:  state_d = ST_TRP;
      ST_TRP:  if (cnt_zero) state_d = ST_FIN;
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Each timed state loads (cycles - 1) on entry and leaves when the count hits zero.
  always_comb begin
    cnt_load     = (state_d != state_q);
    cnt_load_val = '0;
    case (state_d)
      ST_TRCD: cnt_load_val = CNT_W'(T_RCD - 2);
      ST_CASW: cnt_load_val = CNT_W'(CAS_LAT - 2);
      ST_CAP:  cnt_load_val = CNT_W'(BURST_LEN - 1);
      ST_TRP:  cnt_load_val = CNT_W'(T_RP - 1);
      default: cnt_load_val = '0;
    endcase
  end

  // Bus outputs follow the state being entered so command and state change on the same edge.
  always_comb begin
    cmd_d  = CMD_NOP;
    addr_d = '0;
    ba_d   = '0;
    dqm_d  = DQM_ON;
    case (state_d)
      ST_ACT: begin
        cmd_d  = CMD_ACT;
        addr_d = irow;
        ba_d   = ibank;
      end
      ST_RD: begin
        cmd_d              = CMD_READ;
        addr_d[COL_W-1:0]  = col_q;
        addr_d[10]         = AUTO_PRE;
        ba_d               = bank_q;
        dqm_d              = DQM_OFF;
      end
      ST_CASW, ST_CAP: dqm_d = DQM_OFF;
      ST_PRE: begin
        cmd_d = CMD_PRE;
        ba_d  = bank_q;
      end
      default: ;
    endcase
  end

  assign cap_d = (state_d == ST_CAP);

  generate
    if (BURST_LEN == 1) begin : g_acc_single
      assign acc_d = DRAM_DQ;
    end else begin : g_acc_shift
      assign acc_d = {acc_q[ACC_W-DB_WIDTH-1:0], DRAM_DQ};
    end
  endgenerate

  always_ff @(posedge iclk or posedge ctr_reset) begin
    if (ctr_reset) begin
      state_q     <= ST_IDLE;
      col_q       <= '0;
      bank_q      <= '0;
      cmd_q       <= CMD_NOP;
      addr_q      <= '0;
      ba_q        <= '0;
      dqm_q       <= DQM_ON;
      obeat_vld_q <= 1'b0;
      obeat_q     <= '0;
      ofin_q      <= 1'b0;
      acc_q       <= '0;
      odata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      addr_q      <= addr_d;
      ba_q        <= ba_d;
      dqm_q       <= dqm_d;
      obeat_vld_q <= cap_d;
      ofin_q      <= (state_d == ST_FIN);
      if (state_q == ST_IDLE && ireq) begin
        col_q  <= icolumn;
        bank_q <= ibank;
      end
      if (cap_d) begin
        obeat_q <= DRAM_DQ;
        acc_q   <= acc_d;
      end
      if (state_d == ST_FIN) odata_q <= acc_q;
    end
  end

  assign obusy     = (state_q != ST_IDLE);
  assign obeat_vld = obeat_vld_q;
  assign obeat     = obeat_q;
  assign ofin      = ofin_q;
  assign odata     = odata_q;

  // Without the grant every DRAM pin floats so another sequencer can own the bus.
  assign DRAM_CLK   = ienb ? ~iclk    : 1'bz;
  assign DRAM_CKE   = ienb ? 1'b1     : 1'bz;
  assign DRAM_CS_N  = ienb ? cmd_q[3] : 1'bz;
  assign DRAM_RAS_N = ienb ? cmd_q[2] : 1'bz;
  assign DRAM_CAS_N = ienb ? cmd_q[1] : 1'bz;
  assign DRAM_WE_N  = ienb ? cmd_q[0] : 1'bz;
  assign DRAM_UDQM  = ienb ? dqm_q[1] : 1'bz;
  assign DRAM_LDQM  = ienb ? dqm_q[0] : 1'bz;
  assign DRAM_ADDR  = ienb ? addr_q   : {ROW_W{1'bz}};
  assign DRAM_BA    = ienb ? ba_q     : {BA_W{1'bz}};

endmodule

// File: tb/tb_sdram_burst_reader.sv
// Scoreboard bench: default reader (CL2/tRCD2) plus a CL3/tRCD3 instance, each with a tiny SDRAM read model.
module tb_sdram_burst_reader;
  import sdram_pkg::*;

  localparam int BL = 8;

`ifdef SDRAM_RD_AUTO_PRECHARGE_EN
  localparam bit AP = 1'b1;
`else
  localparam bit AP = 1'b0;
`endif

  localparam logic [127:0] ODATA_PLAIN = 128'h11112222333344445555666677778888;
  localparam logic [127:0] ODATA_F0F0  = 128'hE1E1D2D2C3C3B4B4A5A5969687877878;

  logic        clk = 1'b0;
  logic        rst;
  logic        ireq, ienb;
  logic [12:0] irow;
  logic [9:0]  icol;
  logic [1:0]  ibank;
  logic [15:0] pat_mask;
  int          cyc = 0;

  wire          a_busy, a_vld, a_fin, a_clk, a_cke, a_cs, a_ras, a_cas, a_we, a_ldqm, a_udqm;
  wire [15:0]   a_beat;
  wire [127:0]  a_odata;
  wire [12:0]   a_addr;
  wire [1:0]    a_ba;
  logic [15:0]  a_dq;
  wire          b_busy, b_vld, b_fin, b_clk, b_cke, b_cs, b_ras, b_cas, b_we, b_ldqm, b_udqm;
  wire [15:0]   b_beat;
  wire [127:0]  b_odata;
  wire [12:0]   b_addr;
  wire [1:0]    b_ba;
  logic [15:0]  b_dq;

  wire [3:0] a_cmd = {a_cs, a_ras, a_cas, a_we};
  wire [3:0] b_cmd = {b_cs, b_ras, b_cas, b_we};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sdram_burst_reader u_dut (
    .iclk(clk), .ctr_reset(rst), .ireq(ireq), .ienb(ienb),
    .irow(irow), .icolumn(icol), .ibank(ibank),
    .obusy(a_busy), .obeat_vld(a_vld), .obeat(a_beat), .ofin(a_fin), .odata(a_odata),
    .DRAM_CLK(a_clk), .DRAM_CKE(a_cke), .DRAM_CS_N(a_cs), .DRAM_RAS_N(a_ras),
    .DRAM_CAS_N(a_cas), .DRAM_WE_N(a_we), .DRAM_LDQM(a_ldqm), .DRAM_UDQM(a_udqm),
    .DRAM_ADDR(a_addr), .DRAM_BA(a_ba), .DRAM_DQ(a_dq)
  );

  sdram_burst_reader #(.CAS_LAT(3), .T_RCD(3)) u_dut_cl3 (
    .iclk(clk), .ctr_reset(rst), .ireq(ireq), .ienb(ienb),
    .irow(irow), .icolumn(icol), .ibank(ibank),
    .obusy(b_busy), .obeat_vld(b_vld), .obeat(b_beat), .ofin(b_fin), .odata(b_odata),
    .DRAM_CLK(b_clk), .DRAM_CKE(b_cke), .DRAM_CS_N(b_cs), .DRAM_RAS_N(b_ras),
    .DRAM_CAS_N(b_cas), .DRAM_WE_N(b_we), .DRAM_LDQM(b_ldqm), .DRAM_UDQM(b_udqm),
    .DRAM_ADDR(b_addr), .DRAM_BA(b_ba), .DRAM_DQ(b_dq)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] beat_val(input int k, input logic [15:0] m);
    return (16'h1111 * 16'(k + 1)) ^ m;
  endfunction

  // SDRAM models: beat k is driven from the negedge before the edge READ_edge + CAS_LAT + k.
  int a_since = -1;
  int b_since = -1;
  always @(negedge clk) begin
    if (a_cmd == CMD_READ) a_since = 0;
    else if (a_since >= 0 && a_since < 1000) a_since++;
    if (a_since >= 1 && a_since - 1 < BL) a_dq = beat_val(a_since - 1, pat_mask);
    else a_dq = 16'hDEAD;
    if (b_cmd == CMD_READ) b_since = 0;
    else if (b_since >= 0 && b_since < 1000) b_since++;
    if (b_since >= 2 && b_since - 2 < BL) b_dq = beat_val(b_since - 2, pat_mask);
    else b_dq = 16'hDEAD;
  end

  typedef struct packed {
    logic         is_fin;
    logic [127:0] data;
  } exp_t;
  exp_t sb_q[$];

  task automatic push_burst(input logic [15:0] m, input logic [127:0] od);
    exp_t e;
    for (int k = 0; k < BL; k++) begin
      e.is_fin = 1'b0;
      e.data   = 128'(beat_val(k, m));
      sb_q.push_back(e);
    end
    e.is_fin = 1'b1;
    e.data   = od;
    sb_q.push_back(e);
  endtask

  // Scoreboard monitor for the default instance.
  logic a_prev_fin = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (a_vld) begin
      chk("beat_expected", 128'(sb_q.size() != 0), 128'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("beat_kind", 128'(e.is_fin), 128'd0);
        chk("beat_data", 128'(a_beat), e.data);
      end
    end
    if (a_fin) begin
      chk("fin_expected", 128'(sb_q.size() != 0), 128'd1);
      chk("ofin_one_cycle", 128'(a_prev_fin), 128'd0);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("fin_kind", 128'(e.is_fin), 128'd1);
        chk("odata_at_fin", a_odata, e.data);
      end
      $display("burst complete at cycle %0d odata=0x%032h", cyc, a_odata);
    end
    a_prev_fin = a_fin;
  end

  // Bus/event recorders.
  int a_act_n = 0, a_act_cyc = 0, a_rd_cyc = 0, a_pre_n = 0, a_pre_cyc = 0;
  int a_fin_n = 0, a_fin_cyc = 0, a_dqm_lo = 0, a_vld_n = 0, a_first_vld = 0, a_last_vld = 0;
  logic [12:0] a_act_addr = '0, a_rd_addr = '0, a_pre_addr = '0;
  logic [1:0]  a_act_ba = '0, a_pre_ba = '0;
  logic        a_prev_vld = 1'b0;
  int b_act_cyc = 0, b_rd_cyc = 0, b_first_vld = 0, b_dqm_lo = 0, b_fin_n = 0;
  logic [127:0] b_odata_fin = '0;
  logic         b_prev_vld = 1'b0;

  always @(negedge clk) begin
    if (a_cmd == CMD_ACT) begin a_act_n++; a_act_cyc = cyc; a_act_addr = a_addr; a_act_ba = a_ba; end
    if (a_cmd == CMD_READ) begin a_rd_cyc = cyc; a_rd_addr = a_addr; end
    if (a_cmd == CMD_PRE) begin a_pre_n++; a_pre_cyc = cyc; a_pre_addr = a_addr; a_pre_ba = a_ba; end
    if ({a_udqm, a_ldqm} == 2'b00) a_dqm_lo++;
    if (a_vld) begin
      if (!a_prev_vld) a_first_vld = cyc;
      a_last_vld = cyc;
      a_vld_n++;
    end
    a_prev_vld = a_vld;
    if (a_fin) begin a_fin_n++; a_fin_cyc = cyc; end
    if (b_cmd == CMD_ACT) b_act_cyc = cyc;
    if (b_cmd == CMD_READ) b_rd_cyc = cyc;
    if ({b_udqm, b_ldqm} == 2'b00) b_dqm_lo++;
    if (b_vld && !b_prev_vld) b_first_vld = cyc;
    b_prev_vld = b_vld;
    if (b_fin) begin b_fin_n++; b_odata_fin = b_odata; end
  end

  task automatic wait_act(input int target);
    int i = 0;
    while (a_act_n < target && i < 200) begin @(negedge clk); #1; i++; end
    chk("act_timeout", 128'(a_act_n >= target), 128'd1);
  endtask

  task automatic wait_fin(input int target);
    int i = 0;
    while (a_fin_n < target && i < 200) begin @(negedge clk); #1; i++; end
    chk("fin_timeout", 128'(a_fin_n >= target), 128'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int i;
    int fin0, act0, prev_fin;
    rst = 1'b1; ireq = 1'b0; ienb = 1'b1; irow = '0; icol = '0; ibank = '0; pat_mask = '0;
    repeat (3) @(negedge clk);
    chk("rst_cmd", 128'(a_cmd), 128'(CMD_NOP));
    chk("rst_dqm", 128'({a_udqm, a_ldqm}), 128'd3);
    chk("rst_addr", 128'(a_addr), 128'd0);
    chk("rst_ba", 128'(a_ba), 128'd0);
    chk("rst_cke", 128'(a_cke), 128'd1);
    chk("rst_busy", 128'(a_busy), 128'd0);
    chk("rst_vld", 128'(a_vld), 128'd0);
    chk("rst_beat", 128'(a_beat), 128'd0);
    chk("rst_fin", 128'(a_fin), 128'd0);
    chk("rst_odata", a_odata, 128'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Burst 1: row 0x0123, col 0x045, bank 2, single-cycle request.
    a_pre_n = 0; a_dqm_lo = 0; a_vld_n = 0; b_dqm_lo = 0;
    irow = 13'h0123; icol = 10'h045; ibank = 2'd2; ireq = 1'b1;
    push_burst(16'h0000, ODATA_PLAIN);
    @(posedge clk); #1 ireq = 1'b0;
    wait_fin(1);
    i = 0;
    while (b_fin_n < 1 && i < 50) begin @(negedge clk); #1; i++; end
    chk("b_fin_timeout", 128'(b_fin_n >= 1), 128'd1);
    chk("act_addr", 128'(a_act_addr), 128'h0123);
    chk("act_ba", 128'(a_act_ba), 128'd2);
    chk("act_to_read", 128'(a_rd_cyc - a_act_cyc), 128'd2);
    chk("read_addr", 128'(a_rd_addr), AP ? 128'h0445 : 128'h0045);
    chk("act_to_fin", 128'(a_fin_cyc - a_act_cyc), AP ? 128'd14 : 128'd15);
    chk("read_to_beat0", 128'(a_first_vld - a_rd_cyc), 128'd2);
    chk("beat_span", 128'(a_last_vld - a_first_vld), 128'd7);
    chk("beat_count", 128'(a_vld_n), 128'd8);
    chk("dqm_low_cycles", 128'(a_dqm_lo), 128'd10);
    chk("pre_count", 128'(a_pre_n), AP ? 128'd0 : 128'd1);
`ifndef SDRAM_RD_AUTO_PRECHARGE_EN
    chk("pre_after_last_beat", 128'(a_pre_cyc - a_last_vld), 128'd1);
    chk("pre_a10", 128'(a_pre_addr[10]), 128'd0);
    chk("pre_ba", 128'(a_pre_ba), 128'd2);
`endif
    chk("cl3_act_to_read", 128'(b_rd_cyc - b_act_cyc), 128'd3);
    chk("cl3_read_to_beat0", 128'(b_first_vld - b_rd_cyc), 128'd3);
    chk("cl3_dqm_low_cycles", 128'(b_dqm_lo), 128'd11);
    chk("cl3_odata", b_odata_fin, ODATA_PLAIN);
    repeat (5) @(negedge clk);
    chk("odata_held", a_odata, ODATA_PLAIN);
    chk("idle_busy", 128'(a_busy), 128'd0);

    // Reset during the fourth beat aborts the burst without a FIN or PRE.
    @(posedge clk); #1;
    a_vld_n = 0; a_pre_n = 0;
    irow = 13'h0777; icol = 10'h010; ibank = 2'd3; ireq = 1'b1;
    push_burst(16'h0000, ODATA_PLAIN);
    @(posedge clk); #1 ireq = 1'b0;
    i = 0;
    while (a_vld_n < 4 && i < 50) begin @(negedge clk); #1; i++; end
    chk("beat4_timeout", 128'(a_vld_n >= 4), 128'd1);
    fin0 = a_fin_n;
    rst = 1'b1;
    sb_q.delete();
    @(negedge clk);
    chk("abort_cmd", 128'(a_cmd), 128'(CMD_NOP));
    chk("abort_dqm", 128'({a_udqm, a_ldqm}), 128'd3);
    chk("abort_busy", 128'(a_busy), 128'd0);
    chk("abort_odata", a_odata, 128'd0);
    chk("abort_vld", 128'(a_vld), 128'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (30) @(negedge clk);
    chk("abort_no_fin", 128'(a_fin_n - fin0), 128'd0);
    chk("abort_no_pre", 128'(a_pre_n), 128'd0);

    // Back-to-back bursts with ireq held high; dropped once the third ACT is out.
    @(posedge clk); #1;
    pat_mask = 16'hF0F0;
    irow = 13'h1ABC; icol = 10'h3FF; ibank = 2'd1; ireq = 1'b1;
    for (int b = 0; b < 3; b++) push_burst(16'hF0F0, ODATA_F0F0);
    act0 = a_act_n; fin0 = a_fin_n; prev_fin = 0;
    for (int b = 0; b < 3; b++) begin
      wait_act(act0 + b + 1);
      if (b == 0) begin
        chk("b2b_act_addr", 128'(a_act_addr), 128'h1ABC);
        chk("b2b_act_ba", 128'(a_act_ba), 128'd1);
      end else begin
        chk("fin_to_next_act", 128'(a_act_cyc - prev_fin), 128'd2);
      end
      if (b == 2) ireq = 1'b0;
      wait_fin(fin0 + b + 1);
      prev_fin = a_fin_cyc;
    end
    chk("b2b_read_addr", 128'(a_rd_addr), AP ? 128'h07FF : 128'h03FF);
`ifndef SDRAM_RD_AUTO_PRECHARGE_EN
    chk("b2b_pre_ba", 128'(a_pre_ba), 128'd1);
`endif
    repeat (20) @(negedge clk);
    chk("b2b_fin_count", 128'(a_fin_n - fin0), 128'd3);
    chk("b2b_act_count", 128'(a_act_n - act0), 128'd3);
    chk("b2b_sb_drained", 128'(sb_q.size()), 128'd0);
    chk("b2b_odata_held", a_odata, ODATA_F0F0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
